// File: rtl/axi_write_queue_pkg.sv
// Shared types for the AXI-Lite write queue: queued entry layout and control FSM states.
package axi_write_queue_pkg;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_entry_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      STALL = 2'd2
   } wq_state_e;

endpackage

// File: rtl/ADAM_SEQ.sv
// Clock/reset bundle shared by sequential blocks; rst is synchronous and active-high.
interface ADAM_SEQ;
   logic clk;
   logic rst;

   modport Master (output clk, rst);
   modport Slave  (input  clk, rst);
endinterface

// File: rtl/wq_fifo.sv
// Circular buffer of write entries with wrapping pointers, count, and a flush that discards everything.
module wq_fifo
   import axi_write_queue_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   push_i,
   input  wr_entry_t              entry_i,
   input  logic                   pop_i,
   input  logic                   flush_i,
   output wr_entry_t              head_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   full_o,
   output logic                   empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   wr_entry_t     mem_q [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [AW:0]   count_q, count_d;
   logic          wr_en, rd_en;

   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rptr_q];

   // A pop in the same cycle frees the slot, so a push into a full buffer still lands.
   assign rd_en = pop_i && !flush_i && !empty_o;
   assign wr_en = push_i && !flush_i && (!full_o || rd_en);

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (flush_i) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (wr_en) wptr_d = wptr_q + 1'b1;
         if (rd_en) rptr_d = rptr_q + 1'b1;
         count_d = count_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         mem_q   <= '{default: '0};
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         if (wr_en) mem_q[wptr_q] <= entry_i;
      end
   end

endmodule

// File: rtl/axi_write_queue.sv
// Buffered FIFO write-request source with ack watchdog for the arbiter's FSM side.
// Optional AXI_WRITE_QUEUE_STATS_EN adds wr_count_o and hwm_o statistics outputs.
module axi_write_queue
   import axi_write_queue_pkg::*;
#(
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned TIMEOUT = 1023
) (
   ADAM_SEQ.Slave                 seq_port,
   input  logic                   push_valid_i,
   output logic                   push_ready_o,
   input  logic [31:0]            push_addr_i,
   input  logic [31:0]            push_data_i,
   input  logic                   flush_i,
   output logic                   req_o,
   output logic [31:0]            adress_o,
   output logic [31:0]            data_o,
   input  logic                   ack_i,
   output logic [$clog2(DEPTH):0] level_o,
   output logic                   timeout_o,
   output logic                   idle_o
`ifdef AXI_WRITE_QUEUE_STATS_EN
   ,
   output logic [31:0]            wr_count_o,
   output logic [$clog2(DEPTH):0] hwm_o
`endif
);

   localparam int unsigned LW = $clog2(DEPTH) + 1;
   localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   logic          clk, rst;
   wq_state_e     state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          timeout_q, timeout_d;
   logic          pop, push_fire;
   wr_entry_t     push_entry, head;
   logic [LW-1:0] fifo_count;
   logic          fifo_full, fifo_empty;

   assign clk = seq_port.clk;
   assign rst = seq_port.rst;

   assign push_entry = '{addr: push_addr_i, data: push_data_i};
   assign pop        = (state_q == ISSUE) && ack_i && !flush_i;
   assign push_fire  = push_valid_i && !flush_i && (!fifo_full || pop);

   wq_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .push_i  (push_fire),
      .entry_i (push_entry),
      .pop_i   (pop),
      .flush_i (flush_i),
      .head_o  (head),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      timeout_d = timeout_q;
      if (flush_i) begin
         state_d   = IDLE;
         timer_d   = '0;
         timeout_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               timer_d = '0;
               if (push_fire || !fifo_empty) state_d = ISSUE;
            end
            ISSUE: begin
               if (pop) begin
                  timer_d = '0;
                  state_d = ((fifo_count > LW'(1)) || push_fire) ? ISSUE : IDLE;
               end else if (TIMEOUT != 0) begin
                  if (timer_q == TW'(TIMEOUT)) begin
                     state_d   = STALL;
                     timeout_d = 1'b1;
                     timer_d   = '0;
                  end else begin
                     timer_d = timer_q + 1'b1;
                  end
               end
            end
            STALL:   state_d = STALL;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         timer_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         timeout_q <= timeout_d;
      end
   end

   assign req_o        = (state_q == ISSUE);
   assign adress_o     = head.addr;
   assign data_o       = head.data;
   assign level_o      = fifo_count;
   assign timeout_o    = timeout_q;
   assign idle_o       = (state_q == IDLE) && fifo_empty;
   assign push_ready_o = !fifo_full;

`ifdef AXI_WRITE_QUEUE_STATS_EN
   logic [31:0]   wr_count_q, wr_count_d;
   logic [LW-1:0] hwm_q, hwm_d;

   // Survives flush on purpose: these describe lifetime traffic since reset.
   always_comb begin
      wr_count_d = wr_count_q + 32'(pop);
      hwm_d      = (fifo_count > hwm_q) ? fifo_count : hwm_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_count_q <= '0;
         hwm_q      <= '0;
      end else begin
         wr_count_q <= wr_count_d;
         hwm_q      <= hwm_d;
      end
   end

   assign wr_count_o = wr_count_q;
   assign hwm_o      = hwm_q;
`endif

endmodule

// File: tb/tb_axi_write_queue.sv
// Self-checking bench for axi_write_queue: directed vector table, corner sequences, random traffic vs queue model.
module tb_axi_write_queue;

   localparam int DEPTH = 8;
   localparam int TMO   = 15;

   ADAM_SEQ seq();

   logic        pv, fl, ak;
   logic [31:0] pa, pd;
   logic        push_ready_o, req_o, timeout_o, idle_o;
   logic [31:0] adress_o, data_o;
   logic [3:0]  level_o;
`ifdef AXI_WRITE_QUEUE_STATS_EN
   logic [31:0] wr_count_o;
   logic [3:0]  hwm_o;
`endif

   axi_write_queue #(
      .DEPTH   (DEPTH),
      .TIMEOUT (TMO)
   ) dut (
      .seq_port     (seq),
      .push_valid_i (pv),
      .push_ready_o (push_ready_o),
      .push_addr_i  (pa),
      .push_data_i  (pd),
      .flush_i      (fl),
      .req_o        (req_o),
      .adress_o     (adress_o),
      .data_o       (data_o),
      .ack_i        (ak),
      .level_o      (level_o),
      .timeout_o    (timeout_o),
      .idle_o       (idle_o)
`ifdef AXI_WRITE_QUEUE_STATS_EN
      ,
      .wr_count_o   (wr_count_o),
      .hwm_o        (hwm_o)
`endif
   );

   initial begin
      seq.clk = 1'b0;
      forever #5 seq.clk = ~seq.clk;
   end

   int total = 0;
   int bad   = 0;

   // Reference model: the queue contents plus whether the head is stuck after a watchdog expiry.
   logic [63:0] mq[$];
   bit          stuck;
   int          age;
   int unsigned wr_cnt;
   int          hwm;

   typedef struct {
      bit          rst, pv, fl, ak;
      logic [31:0] a, d;
      int          lvl;
      bit          req, to, idle, rdy, chka;
      logic [31:0] ea, ed;
   } vec_t;
   vec_t vq[$];

   task automatic check(input string nm, input longint unsigned act, input longint unsigned exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=0x%0h want=0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_step();
      bit req, popped, acc;
      int sz;
      if (seq.rst) begin
         mq.delete();
         stuck = 0; age = 0; wr_cnt = 0; hwm = 0;
         return;
      end
      sz = mq.size();
      if (sz > hwm) hwm = sz;
      if (fl) begin
         mq.delete();
         stuck = 0; age = 0;
         return;
      end
      req    = (sz > 0) && !stuck;
      popped = req && ak;
      acc    = pv && ((sz < DEPTH) || popped);
      if (popped) begin
         void'(mq.pop_front());
         age = 0;
         wr_cnt++;
      end else if (req) begin
         if (age == TMO) begin
            stuck = 1;
            age   = 0;
         end else begin
            age++;
         end
      end
      if (acc) mq.push_back({pa, pd});
   endtask

   task automatic check_model();
      bit er;
      er = (mq.size() > 0) && !stuck;
      check("m_level",   64'(level_o),      64'(mq.size()));
      check("m_req",     64'(req_o),        64'(er));
      check("m_timeout", 64'(timeout_o),    64'(stuck));
      check("m_idle",    64'(idle_o),       64'(mq.size() == 0));
      check("m_ready",   64'(push_ready_o), 64'(mq.size() < DEPTH));
      if (er) begin
         check("m_addr", 64'(adress_o), 64'(mq[0][63:32]));
         check("m_data", 64'(data_o),   64'(mq[0][31:0]));
      end
`ifdef AXI_WRITE_QUEUE_STATS_EN
      check("m_wr_count", 64'(wr_count_o), 64'(wr_cnt));
      check("m_hwm",      64'(hwm_o),      64'(hwm));
`endif
   endtask

   task automatic tick();
      @(posedge seq.clk);
      model_step();
      #1;
      check_model();
   endtask

   task automatic idle_inputs();
      seq.rst = 1'b0; pv = 1'b0; fl = 1'b0; ak = 1'b0; pa = '0; pd = '0;
   endtask

   task automatic addv(input bit r, input bit p, input bit f, input bit k,
                       input logic [31:0] a, input logic [31:0] d, input int lvl,
                       input bit req, input bit idle, input bit chka,
                       input logic [31:0] ea, input logic [31:0] ed);
      vec_t v;
      v.rst = r; v.pv = p; v.fl = f; v.ak = k; v.a = a; v.d = d;
      v.lvl = lvl; v.req = req; v.to = 1'b0; v.idle = idle;
      v.rdy = (lvl < DEPTH); v.chka = chka; v.ea = ea; v.ed = ed;
      vq.push_back(v);
   endtask

   task automatic push_n(input int n, input logic [31:0] base);
      for (int i = 0; i < n; i++) begin
         pv = 1'b1; pa = base + 32'(4 * i); pd = base + 32'(i);
         tick();
      end
      pv = 1'b0;
   endtask

   task automatic pop_n(input int n);
      for (int i = 0; i < n; i++) begin
         ak = 1'b1; tick();
         ak = 1'b0; tick();
      end
   endtask

   initial begin
      int k;
      idle_inputs();
      seq.rst = 1'b1;

      // Directed vectors: reset, three pushes, acks three cycles apart, stray ack when empty.
      addv(1, 0, 0, 0, 0,         0,   0, 0, 1, 1, 32'h0,   32'h0);
      addv(0, 1, 0, 0, 32'h100, 32'hA, 1, 1, 0, 1, 32'h100, 32'hA);
      addv(0, 1, 0, 0, 32'h104, 32'hB, 2, 1, 0, 1, 32'h100, 32'hA);
      addv(0, 1, 0, 0, 32'h108, 32'hC, 3, 1, 0, 1, 32'h100, 32'hA);
      addv(0, 0, 0, 0, 0,         0,   3, 1, 0, 1, 32'h100, 32'hA);
      addv(0, 0, 0, 1, 0,         0,   2, 1, 0, 1, 32'h104, 32'hB);
      addv(0, 0, 0, 0, 0,         0,   2, 1, 0, 1, 32'h104, 32'hB);
      addv(0, 0, 0, 0, 0,         0,   2, 1, 0, 1, 32'h104, 32'hB);
      addv(0, 0, 0, 1, 0,         0,   1, 1, 0, 1, 32'h108, 32'hC);
      addv(0, 0, 0, 0, 0,         0,   1, 1, 0, 1, 32'h108, 32'hC);
      addv(0, 0, 0, 0, 0,         0,   1, 1, 0, 1, 32'h108, 32'hC);
      addv(0, 0, 0, 1, 0,         0,   0, 0, 1, 0, 32'h0,   32'h0);
      addv(0, 0, 0, 1, 0,         0,   0, 0, 1, 0, 32'h0,   32'h0);

      foreach (vq[i]) begin
         seq.rst = vq[i].rst; pv = vq[i].pv; fl = vq[i].fl; ak = vq[i].ak;
         pa = vq[i].a; pd = vq[i].d;
         tick();
         check("v_level",   64'(level_o),      64'(vq[i].lvl));
         check("v_req",     64'(req_o),        64'(vq[i].req));
         check("v_timeout", 64'(timeout_o),    64'(vq[i].to));
         check("v_idle",    64'(idle_o),       64'(vq[i].idle));
         check("v_ready",   64'(push_ready_o), 64'(vq[i].rdy));
         if (vq[i].chka) begin
            check("v_addr", 64'(adress_o), 64'(vq[i].ea));
            check("v_data", 64'(data_o),   64'(vq[i].ed));
         end
      end
      idle_inputs();

      // Full queue, then push together with ack: level holds and the new entry goes last.
      push_n(DEPTH, 32'h200);
      check("full_ready", 64'(push_ready_o), 64'(0));
      check("full_level", 64'(level_o), 64'(DEPTH));
      pv = 1'b1; pa = 32'h300; pd = 32'h3; ak = 1'b1;
      tick();
      pv = 1'b0; ak = 1'b0;
      check("full_pushack_level", 64'(level_o), 64'(DEPTH));
      tick();
      pop_n(DEPTH - 1);
      check("full_last_addr", 64'(adress_o), 64'(32'h300));
      check("full_last_level", 64'(level_o), 64'(1));
      pop_n(1);
      check("full_drained_idle", 64'(idle_o), 64'(1));

      // Watchdog: no ack for TIMEOUT+1 cycles of req.
      push_n(1, 32'h400);
      k = 0;
      while (k < 40 && !timeout_o) begin
         tick();
         k++;
      end
      check("to_cycle", 64'(k), 64'(TMO + 1));
      check("to_req_low", 64'(req_o), 64'(0));
      ak = 1'b1; tick(); ak = 1'b0;
      check("to_ack_ignored", 64'(level_o), 64'(1));
      check("to_sticky", 64'(timeout_o), 64'(1));
      fl = 1'b1; tick(); fl = 1'b0;
      check("to_flush_clear", 64'(timeout_o), 64'(0));
      check("to_flush_idle", 64'(idle_o), 64'(1));

      // Flush with a simultaneous push drops everything including the push.
      push_n(5, 32'h500);
      check("fl_req", 64'(req_o), 64'(1));
      fl = 1'b1; pv = 1'b1; pa = 32'h5FC; pd = 32'h55;
      tick();
      fl = 1'b0; pv = 1'b0;
      check("fl_level", 64'(level_o), 64'(0));
      tick(); tick();
      check("fl_push_absent", 64'(level_o), 64'(0));
      check("fl_req_low", 64'(req_o), 64'(0));

      // Reset while issuing with four entries queued.
      push_n(4, 32'h600);
      seq.rst = 1'b1; tick(); seq.rst = 1'b0;
      check("rst_level", 64'(level_o), 64'(0));
      check("rst_req", 64'(req_o), 64'(0));
      check("rst_addr", 64'(adress_o), 64'(0));
      check("rst_data", 64'(data_o), 64'(0));
      check("rst_idle", 64'(idle_o), 64'(1));
      check("rst_ready", 64'(push_ready_o), 64'(1));
      push_n(1, 32'h700);
      check("rst_push_req", 64'(req_o), 64'(1));

`ifdef AXI_WRITE_QUEUE_STATS_EN
      seq.rst = 1'b1; tick(); seq.rst = 1'b0;
      push_n(6, 32'h800);
      pop_n(6);
      push_n(4, 32'h900);
      pop_n(4);
      check("st_wr_count", 64'(wr_count_o), 64'(10));
      check("st_hwm", 64'(hwm_o), 64'(6));
      fl = 1'b1; tick(); fl = 1'b0; tick();
      check("st_wr_count_flush", 64'(wr_count_o), 64'(10));
      check("st_hwm_flush", 64'(hwm_o), 64'(6));
`endif

      // Random traffic against the model; slower acks in the second half provoke timeouts.
      for (int c = 0; c < 800; c++) begin
         seq.rst = ($urandom_range(0, 249) == 0);
         fl      = ($urandom_range(0, 59) == 0);
         pv      = (mq.size() < DEPTH) && ($urandom_range(0, 1) == 1);
         pa      = $urandom;
         pd      = $urandom;
         ak      = !ak && ($urandom_range(0, (c < 400) ? 2 : 14) == 0);
         tick();
      end
      idle_inputs();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/axi_write_queue.md
# axi_write_queue

Buffered write-request source feeding the low-priority (FSM) side of the AXI-Lite write arbiter. Control FSMs push address/data write entries in bursts. The queue presents them one at a time on the arbiter's req/ack interface, in FIFO order. A watchdog flags writes that are never acknowledged, so one stuck slave cannot silently stall the control path.

## Interface
- DEPTH, 8: entries stored; power of two, 2..64.
- TIMEOUT, 1023: max cycles req_o may stay high without ack_i; 0 disables the watchdog.
- seq_port  input  ADAM_SEQ.Slave  carries clk and rst; one clock; reset is synchronous and active-high.
- push_valid_i  input  1  producer offers an entry.
- push_ready_o  output  1  queue can accept; combinational `!full`.
- push_addr_i  input  32  write address.
- push_data_i  input  32  write data.
- flush_i  input  1  discard all queued entries not yet in flight.
- req_o  output  1  to arbiter fsm_req_i.
- adress_o  output  32  to arbiter fsm_adress_i.
- data_o  output  32  to arbiter fsm_data_i.
- ack_i  input  1  from arbiter fsm_ack_o; one-cycle pulse.
- level_o  output  $clog2(DEPTH)+1  entries held, including the in-flight one.
- timeout_o  output  1  sticky error; cleared by flush_i.
- idle_o  output  1  queue empty, no entry in flight.

## Operation
- Storage is a circular buffer with wrapping read/write pointers and a count register.
- States:
  - IDLE: queue empty.
  - ISSUE: req_o=1, head presented, timer counting.
  - STALL: timeout hit; req_o=0; head retained.
- IDLE → ISSUE when count becomes nonzero.
- ISSUE on ack_i:
  - pop the head, reset the timer;
  - go to ISSUE if the count after the pop is nonzero, else to IDLE.
- ISSUE → STALL when the timer reaches TIMEOUT without ack_i; set timeout_o.
- STALL → IDLE on flush_i.
- Push and ack in the same cycle: both take effect; count unchanged.
- Push when full is ignored. push_ready_o=0 forbids it; the bench asserts this never happens.
- Push while in STALL is accepted if not full.
- adress_o/data_o are driven directly from the head entry. They are stable for as long as req_o=1.
- flush_i:
  - clears pointers, count, timer and timeout_o;
  - state → IDLE;
  - a simultaneous push is dropped.
- An ack_i that arrives in the cycle of a flush is ignored. An ack_i that arrives in IDLE or STALL is ignored.
- A write already accepted by the arbiter before a flush completes on the bus. The queue no longer tracks it.

## Timing
- Reset values:
  - req_o=0, adress_o=0, data_o=0;
  - level_o=0, timeout_o=0, idle_o=1, push_ready_o=1;
  - pointers, count and timer = 0; state IDLE.
- Push at edge N into an empty queue: req_o=1 from cycle N+1 (one-cycle latency).
- ack_i sampled at edge M: the next head and req_o are valid from cycle M+1. The arbiter re-samples only after its ack has dropped, so every pop is seen exactly once.
- Timer:
  - increments every cycle in ISSUE;
  - timeout_o rises in the cycle after the timer equals TIMEOUT.
- Reset mid-operation returns to the reset values above on the next edge. Queued data is lost.

## Configuration
- AXI_WRITE_QUEUE_STATS_EN defined:
  - adds output wr_count_o (32 b), incremented per ack_i pop, wraps at 2^32;
  - adds output hwm_o ($clog2(DEPTH)+1 b), the high-water mark of count;
  - both cleared by reset only, not by flush.
- Not defined: neither port nor register exists.

## Structure
- Package axi_write_queue_pkg holds:
  - typedef wr_entry_t, a packed {addr[31:0], data[31:0]};
  - typedef wq_state_e {IDLE, ISSUE, STALL}.
- Sub-module wq_fifo: parameterised circular buffer of wr_entry_t with push/pop/flush, count, full and empty.
- The top holds the FSM, the watchdog and the stats.

## Test plan
- Push (0x100,0xA), (0x104,0xB), (0x108,0xC) on back-to-back cycles; ack 3 cycles after each req → arbiter sees 0x100, 0x104, 0x108 in order; level_o goes 3,2,1,0; idle_o=1 at the end.
- Fill with DEPTH=8 entries → push_ready_o=0 and level_o=8. Push and ack in the same cycle → level_o stays 8, the new entry is last.
- TIMEOUT=15, no ack → timeout_o=1 at cycle 16 after req_o rose; req_o=0; a later ack_i is ignored. flush_i → timeout_o=0, idle_o=1.
- Five entries queued, first one in ISSUE; assert flush_i together with push_valid_i → level_o=0 next cycle and the pushed entry is absent.
- Assert rst while in ISSUE with 4 entries → all reset values on the next cycle. A push afterwards gives req_o one cycle later.
- STATS_EN defined: 10 writes acked with peak occupancy 6 → wr_count_o=10, hwm_o=6; both unchanged by a flush.
